// File: rtl/axil_reg_bridge.sv
// AXI-lite slave to single-request/acknowledge register bus bridge.
// The write and read paths each have their own FSM and ack timeout.
module axil_reg_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_ack,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_ack
);
  localparam int         LSB     = $clog2(STRB_WIDTH);
  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP} wr_st_e;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP} rd_st_e;

  wr_st_e                wr_st_q, wr_st_d;
  logic [7:0]            wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic                  wr_en_q, wr_en_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;

  rd_st_e                rd_st_q, rd_st_d;
  logic [7:0]            rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;

  logic wr_accept, wr_tmo, rd_accept, rd_tmo;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[LSB-1:0], s_axil_araddr[LSB-1:0]};

  // AW and W are only taken together; readies stay low while in reset.
  assign wr_accept      = rst_n && (wr_st_q == WR_IDLE) && s_axil_awvalid && s_axil_wvalid;
  assign s_axil_awready = wr_accept;
  assign s_axil_wready  = wr_accept;
  assign rd_accept      = rst_n && (rd_st_q == RD_IDLE) && s_axil_arvalid;
  assign s_axil_arready = rd_accept;

  // Ack in the last allowed cycle takes priority over the timeout.
  assign wr_tmo = TO_EN && (wr_cnt_q == TO_LAST) && !reg_wr_ack;
  assign rd_tmo = TO_EN && (rd_cnt_q == TO_LAST) && !reg_rd_ack;

  // Write path next-state and registered outputs.
  always_comb begin
    wr_st_d   = wr_st_q;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_en_d   = wr_en_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    case (wr_st_q)
      WR_IDLE: if (wr_accept) begin
        wr_addr_d = {s_axil_awaddr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
        wr_data_d = s_axil_wdata;
        wr_strb_d = s_axil_wstrb;
        wr_cnt_d  = 8'd0;
        wr_en_d   = 1'b1;
        wr_st_d   = WR_REQ;
      end
      WR_REQ: if (reg_wr_ack || wr_tmo) begin
        wr_en_d  = 1'b0;
        bresp_d  = reg_wr_ack ? 2'b00 : 2'b10;
        bvalid_d = 1'b1;
        wr_st_d  = WR_RESP;
      end else begin
        wr_cnt_d = wr_cnt_q + 8'd1;
      end
      WR_RESP: if (s_axil_bready) begin
        bvalid_d = 1'b0;
        wr_st_d  = WR_IDLE;
      end
      default: wr_st_d = WR_IDLE;
    endcase
  end

  // Read path next-state and registered outputs.
  always_comb begin
    rd_st_d   = rd_st_q;
    rd_cnt_d  = rd_cnt_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    case (rd_st_q)
      RD_IDLE: if (rd_accept) begin
        rd_addr_d = {s_axil_araddr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
        rd_cnt_d  = 8'd0;
        rd_en_d   = 1'b1;
        rd_st_d   = RD_REQ;
      end
      RD_REQ: if (reg_rd_ack || rd_tmo) begin
        rd_en_d  = 1'b0;
        rdata_d  = reg_rd_ack ? reg_rd_data : '0;
        rresp_d  = reg_rd_ack ? 2'b00 : 2'b10;
        rvalid_d = 1'b1;
        rd_st_d  = RD_RESP;
      end else begin
        rd_cnt_d = rd_cnt_q + 8'd1;
      end
      RD_RESP: if (s_axil_rready) begin
        rvalid_d = 1'b0;
        rd_st_d  = RD_IDLE;
      end
      default: rd_st_d = RD_IDLE;
    endcase
  end

  // State registers for both paths; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st_q   <= WR_IDLE;
      wr_cnt_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      wr_en_q   <= 1'b0;
      bresp_q   <= '0;
      bvalid_q  <= 1'b0;
      rd_st_q   <= RD_IDLE;
      rd_cnt_q  <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      wr_en_q   <= wr_en_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      rd_st_q   <= rd_st_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign reg_wr_addr   = wr_addr_q;
  assign reg_wr_data   = wr_data_q;
  assign reg_wr_strb   = wr_strb_q;
  assign reg_wr_en     = wr_en_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_bvalid = bvalid_q;
  assign reg_rd_addr   = rd_addr_q;
  assign reg_rd_en     = rd_en_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rvalid = rvalid_q;
endmodule
